// File: rtl/elevator_floor_controller.sv
// Elevator floor controller: latches floor calls, steps the car one floor per
// slowClk tick with a direction preference, and holds the door open for
// DOOR_TICKS ticks at each served floor.
module elevator_floor_controller #(
    parameter int FLOORS     = 4,
    parameter int FLOOR_BITS = 2,
    parameter int DOOR_TICKS = 3
) (
    input  logic                  clkIn,
    input  logic                  reset,
    input  logic                  slowClk,
    input  logic [FLOORS-1:0]     reqIn,
    output logic [FLOOR_BITS-1:0] currentFloor,
    output logic                  movingUp,
    output logic                  movingDown,
    output logic                  doorOpen,
    output logic [FLOORS-1:0]     pending
);

    typedef enum logic [1:0] {IDLE, UP, DOWN, DOOR} state_t;

    state_t                state, state_n;
    logic                  sync1, sync2, hist, tick;
    logic [FLOOR_BITS-1:0] floor_n;
    logic [3:0]            doorCnt, doorCnt_n;
    logic                  lastUp, lastUp_n;
    logic [FLOORS-1:0]     floorMask, belowMask, aboveMask, clearMask, pending_n;
    logic                  here, above, below, reqHere;

    // Bring slowClk into the clkIn domain and keep one history bit for edge detect
    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= slowClk;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign tick = sync2 & ~hist;

    // Where the latched calls sit relative to the car
    assign floorMask = FLOORS'(1) << currentFloor;
    assign belowMask = floorMask - FLOORS'(1);
    assign aboveMask = ~(belowMask | floorMask);
    assign here      = |(pending & floorMask);
    assign above     = |(pending & aboveMask);
    assign below     = |(pending & belowMask);
    assign reqHere   = |(reqIn & floorMask);

    // Next state, floor, travel direction and door counter
    always_comb begin
        state_n   = state;
        floor_n   = currentFloor;
        doorCnt_n = doorCnt;
        lastUp_n  = lastUp;
        case (state)
            IDLE: begin
                // leaving IDLE already takes the first floor step
                if (tick) begin
                    if (here) begin
                        state_n   = DOOR;
                        doorCnt_n = 4'(DOOR_TICKS);
                    end else if (above && (lastUp || !below)) begin
                        state_n  = UP;
                        floor_n  = currentFloor + FLOOR_BITS'(1);
                        lastUp_n = 1'b1;
                    end else if (below) begin
                        state_n  = DOWN;
                        floor_n  = currentFloor - FLOOR_BITS'(1);
                        lastUp_n = 1'b0;
                    end
                end
            end
            UP: begin
                if (tick) begin
                    if (here) begin
                        state_n   = DOOR;
                        doorCnt_n = 4'(DOOR_TICKS);
                    end else if (above) begin
                        floor_n = currentFloor + FLOOR_BITS'(1);
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DOWN: begin
                if (tick) begin
                    if (here) begin
                        state_n   = DOOR;
                        doorCnt_n = 4'(DOOR_TICKS);
                    end else if (below) begin
                        floor_n = currentFloor - FLOOR_BITS'(1);
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DOOR: begin
                // a fresh call at this floor restarts the door time, even on a closing tick
                if (reqHere) begin
                    doorCnt_n = 4'(DOOR_TICKS);
                end else if (tick) begin
                    if (doorCnt <= 4'd1) begin
                        state_n   = IDLE;
                        doorCnt_n = '0;
                    end else begin
                        doorCnt_n = doorCnt - 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign clearMask = {FLOORS{state_n == DOOR}} & floorMask;
    assign pending_n = (pending | reqIn) & ~clearMask;

    // State, position, call latch and registered status outputs
    always_ff @(posedge clkIn or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            currentFloor <= '0;
            doorCnt      <= '0;
            lastUp       <= 1'b1;
            pending      <= '0;
            movingUp     <= 1'b0;
            movingDown   <= 1'b0;
            doorOpen     <= 1'b0;
        end else begin
            state        <= state_n;
            currentFloor <= floor_n;
            doorCnt      <= doorCnt_n;
            lastUp       <= lastUp_n;
            pending      <= pending_n;
            movingUp     <= (state_n == UP);
            movingDown   <= (state_n == DOWN);
            doorOpen     <= (state_n == DOOR);
        end
    end

endmodule
